rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
Registered, parametrised RISC-V instruction decode stage for the multi-cycle/pipelined core. It sits between fetch and execute and buffers fetched instructions in a DEPTH-entry FIFO. Each instruction is decoded to name, type, rd/rs1/rs2 and a sign-extended XLEN immediate, with valid/ready handshakes on both sides. It adds RV32I coverage beyond the single-cycle set: shifts, SLT*, XOR*, LUI, AUIPC and BLT/BGE*. It also adds flush and a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN; pc width XLEN
DEPTH, 4, input FIFO entries (power of 2, >=2)
CNT_W, 16, illegal-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; discards all buffered and output-held instructions
in_valid  in  1  fetch has instruction
in_ready  out  1  stage can accept (FIFO not full)
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded instruction available
out_ready  in  1  execute accepts
out_pc  out  XLEN  pc of decoded instruction
out_name  out  6  op code: ADD0 SUB1 AND2 OR3 ADDI4 ANDI5 ORI6 LW7 JALR8 BEQ9 BNE10 JAL11 SW12 UNKNOWN13 XOR14 SLL15 SRL16 SRA17 SLT18 SLTU19 XORI20 SLLI21 SRLI22 SRAI23 SLTI24 SLTIU25 LUI26 AUIPC27 BLT28 BGE29 BLTU30 BGEU31
out_type  out  3  R0 I1 B2 J3 S4 UNKNOWN_TYPE5 U6
out_rd  out  5  destination; 0 when out_rd_we=0
out_rd_we  out  1  instruction writes rd (R,I,J,U)
out_rs1  out  5  instr[19:15]; 0 for J/U
out_rs2  out  5  instr[24:20]; 0 unless R/S/B
out_imm  out  XLEN  sign-extended immediate; 0 for R/UNKNOWN
out_illegal  out  1  out_name==UNKNOWN
illegal_cnt  out  CNT_W  saturating count of illegal instructions handed off

Behaviour:
- Reset: FIFO empty, out_valid=0, in_ready=1, all out_* data=0, illegal_cnt=0; out_name=UNKNOWN, out_type=UNKNOWN_TYPE.
- Input push on in_valid&in_ready; in_ready = !full (registered count, no combinational path from out_ready).
- Output register loads the FIFO head when (!out_valid | out_ready) and FIFO non-empty; out_* held stable while out_valid&!out_ready.
- Latency: accepted at edge k into empty stage -> out_valid=1 after edge k+1. Sustained throughput 1/cycle.
- Simultaneous push and pop on a full FIFO: pop frees a slot the next cycle only; in_ready stays 0 that cycle.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; full when MSBs differ and the rest are equal.
- flush: at the next edge, FIFO emptied and out_valid=0; any push in the same cycle is dropped; illegal_cnt unchanged. Flush has priority over push/pop.
- Decode uses opcode [6:0], funct3 [14:12], funct7 [31:25]:
  - 0110011 = R, funct7 0000000/0100000 selects ADD/SUB, SRL/SRA.
  - 0010011 = I; shift-immediates also require funct7 0000000 (0100000 for SRAI, XLEN=32) else UNKNOWN.
  - 0000011 funct3 010 = LW.
  - 1100111 funct3 000 = JALR.
  - 0100011 funct3 010 = SW.
  - 1101111 = JAL.
  - 1100011 = B, funct3 000/001/100/101/110/111 selects BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - 0110111 = LUI.
  - 0010111 = AUIPC.
  - Known opcode with bad funct gives that opcode's type with name UNKNOWN; unknown opcode gives UNKNOWN/UNKNOWN_TYPE.
  - Any UNKNOWN name forces rd_we=0, rd=0 and imm=0.
- Immediates, all sign-extended to XLEN from the MSB of the raw field:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - U: {[31:12],12'b0}, sign-extended for XLEN=64.
  - Shift-immediates: zero-extended shamt [24:20].
- illegal_cnt increments on out_valid&out_ready&out_illegal and saturates at all-ones.
- Async reset mid-operation clears everything immediately; the first push is accepted on the first edge after deassertion.

Test Plan:
- Reset then ADDI x5,x0,-1 (0xFFF00293), pc 0x100, out_ready=1 -> one cycle after accept: name=4, type=1, rd=5, rd_we=1, imm=0xFFFFFFFF, pc=0x100.
- Burst 6 instrs with out_ready=0, DEPTH=4 -> in_ready falls after 5 accepted (4 FIFO + 1 output reg); release out_ready -> all 5 emerge in order, no loss/duplication.
- BLT x1,x2,-4 (0xFE20CEE3) -> name=28, type=2, rd=0, rd_we=0, rs1=1, rs2=2, imm=0xFFFFFFFC; SW x3,8(x4) (0x00322423) -> name=12, rd=0, imm=8.
- LUI x7,0x80000 (0x800003B7) with XLEN=64 -> imm=0xFFFFFFFF80000000, type=6; AUIPC -> name=27.
- Words 0x0000000B and 0x4000F033 -> UNKNOWN/UNKNOWN_TYPE and UNKNOWN/R, illegal=1; counter reaches 2; with CNT_W=2, 5 illegals -> holds 3.
- FIFO with 3 entries, flush asserted together with in_valid -> next cycle out_valid=0, in_ready=1, nothing emerges; the next push decodes normally.

Source files
------------

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for the decode stage.
// The decode stage uses the slave view; the fetch/execute side uses the master view.
interface rv_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Fetch side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    // Execute side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [5:0]      out_name;
    logic [2:0]      out_type;
    logic [4:0]      out_rd;
    logic            out_rd_we;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_name, out_type, out_rd, out_rd_we,
               out_rs1, out_rs2, out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_name, out_type, out_rd, out_rd_we,
               out_rs1, out_rs2, out_imm, out_illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: DEPTH-entry instruction FIFO followed by a registered
// decoder output with valid/ready handshakes, flush and a saturating
// illegal-instruction counter.
module rv_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    rv_decode_stage_if.slave bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [5:0] NmAdd   = 6'd0,  NmSub   = 6'd1,  NmAnd   = 6'd2,  NmOr    = 6'd3;
    localparam logic [5:0] NmAddi  = 6'd4,  NmAndi  = 6'd5,  NmOri   = 6'd6,  NmLw    = 6'd7;
    localparam logic [5:0] NmJalr  = 6'd8,  NmBeq   = 6'd9,  NmBne   = 6'd10, NmJal   = 6'd11;
    localparam logic [5:0] NmSw    = 6'd12, NmUnk   = 6'd13, NmXor   = 6'd14, NmSll   = 6'd15;
    localparam logic [5:0] NmSrl   = 6'd16, NmSra   = 6'd17, NmSlt   = 6'd18, NmSltu  = 6'd19;
    localparam logic [5:0] NmXori  = 6'd20, NmSlli  = 6'd21, NmSrli  = 6'd22, NmSrai  = 6'd23;
    localparam logic [5:0] NmSlti  = 6'd24, NmSltiu = 6'd25, NmLui   = 6'd26, NmAuipc = 6'd27;
    localparam logic [5:0] NmBlt   = 6'd28, NmBge   = 6'd29, NmBltu  = 6'd30, NmBgeu  = 6'd31;

    localparam logic [2:0] TyR = 3'd0, TyI = 3'd1, TyB = 3'd2, TyJ = 3'd3;
    localparam logic [2:0] TyS = 3'd4, TyUnk = 3'd5, TyU = 3'd6;

    localparam logic [6:0] OpcReg   = 7'b0110011, OpcImm  = 7'b0010011, OpcLoad = 7'b0000011;
    localparam logic [6:0] OpcJalr  = 7'b1100111, OpcStore = 7'b0100011, OpcJal = 7'b1101111;
    localparam logic [6:0] OpcBranch = 7'b1100011, OpcLui = 7'b0110111, OpcAuipc = 7'b0010111;

    localparam logic [6:0] F7Zero = 7'b0000000, F7Alt = 7'b0100000;

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic            full, empty, push, pop;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc;

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [31:0]     imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, imm_sel;
    logic [5:0]      dec_name;
    logic [2:0]      dec_type;
    logic            dec_illegal, dec_rd_we;
    logic [4:0]      dec_rd, dec_rs1, dec_rs2;
    logic [XLEN-1:0] dec_imm;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign bus.in_ready = !full;

    // Flush drops both the incoming word and any pending transfer into the output register.
    assign push = bus.in_valid && !full && !flush;
    assign pop  = !empty && (!bus.out_valid || bus.out_ready) && !flush;

    assign head_instr = instr_mem[rd_ptr_q[AW-1:0]];
    assign head_pc    = pc_mem[rd_ptr_q[AW-1:0]];

    // FIFO storage; unreset because only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q[AW-1:0]] <= bus.in_instr;
            pc_mem[wr_ptr_q[AW-1:0]]    <= bus.in_pc;
        end
    end

    // FIFO pointers, one extra bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // Decode the FIFO head into name/type/registers/immediate
    always_comb begin
        opcode   = head_instr[6:0];
        f3       = head_instr[14:12];
        f7       = head_instr[31:25];
        imm_i    = {{20{head_instr[31]}}, head_instr[31:20]};
        imm_s    = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        imm_b    = {{19{head_instr[31]}}, head_instr[31], head_instr[7], head_instr[30:25],
                    head_instr[11:8], 1'b0};
        imm_j    = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12], head_instr[20],
                    head_instr[30:21], 1'b0};
        imm_u    = {head_instr[31:12], 12'b0};
        imm_sh   = {27'b0, head_instr[24:20]};
        imm_sel  = '0;
        dec_name = NmUnk;
        dec_type = TyUnk;
        case (opcode)
            OpcReg: begin
                dec_type = TyR;
                case (f3)
                    3'b000: dec_name = (f7 == F7Zero) ? NmAdd : ((f7 == F7Alt) ? NmSub : NmUnk);
                    3'b001: dec_name = (f7 == F7Zero) ? NmSll  : NmUnk;
                    3'b010: dec_name = (f7 == F7Zero) ? NmSlt  : NmUnk;
                    3'b011: dec_name = (f7 == F7Zero) ? NmSltu : NmUnk;
                    3'b100: dec_name = (f7 == F7Zero) ? NmXor  : NmUnk;
                    3'b101: dec_name = (f7 == F7Zero) ? NmSrl : ((f7 == F7Alt) ? NmSra : NmUnk);
                    3'b110: dec_name = (f7 == F7Zero) ? NmOr   : NmUnk;
                    default: dec_name = (f7 == F7Zero) ? NmAnd : NmUnk;
                endcase
            end
            OpcImm: begin
                dec_type = TyI;
                imm_sel  = imm_i;
                case (f3)
                    3'b000: dec_name = NmAddi;
                    3'b010: dec_name = NmSlti;
                    3'b011: dec_name = NmSltiu;
                    3'b100: dec_name = NmXori;
                    3'b110: dec_name = NmOri;
                    3'b111: dec_name = NmAndi;
                    3'b001: begin
                        dec_name = (f7 == F7Zero) ? NmSlli : NmUnk;
                        imm_sel  = imm_sh;
                    end
                    default: begin
                        dec_name = (f7 == F7Zero) ? NmSrli : ((f7 == F7Alt) ? NmSrai : NmUnk);
                        imm_sel  = imm_sh;
                    end
                endcase
            end
            OpcLoad: begin
                dec_type = TyI;
                imm_sel  = imm_i;
                dec_name = (f3 == 3'b010) ? NmLw : NmUnk;
            end
            OpcJalr: begin
                dec_type = TyI;
                imm_sel  = imm_i;
                dec_name = (f3 == 3'b000) ? NmJalr : NmUnk;
            end
            OpcStore: begin
                dec_type = TyS;
                imm_sel  = imm_s;
                dec_name = (f3 == 3'b010) ? NmSw : NmUnk;
            end
            OpcJal: begin
                dec_type = TyJ;
                imm_sel  = imm_j;
                dec_name = NmJal;
            end
            OpcBranch: begin
                dec_type = TyB;
                imm_sel  = imm_b;
                case (f3)
                    3'b000:  dec_name = NmBeq;
                    3'b001:  dec_name = NmBne;
                    3'b100:  dec_name = NmBlt;
                    3'b101:  dec_name = NmBge;
                    3'b110:  dec_name = NmBltu;
                    3'b111:  dec_name = NmBgeu;
                    default: dec_name = NmUnk;
                endcase
            end
            OpcLui: begin
                dec_type = TyU;
                imm_sel  = imm_u;
                dec_name = NmLui;
            end
            OpcAuipc: begin
                dec_type = TyU;
                imm_sel  = imm_u;
                dec_name = NmAuipc;
            end
            default: dec_name = NmUnk;
        endcase

        dec_illegal = (dec_name == NmUnk);
        dec_rd_we   = !dec_illegal &&
                      (dec_type == TyR || dec_type == TyI || dec_type == TyJ || dec_type == TyU);
        dec_rd      = dec_rd_we ? head_instr[11:7] : 5'd0;
        dec_rs1     = (dec_type == TyJ || dec_type == TyU) ? 5'd0 : head_instr[19:15];
        dec_rs2     = (dec_type == TyR || dec_type == TyS || dec_type == TyB) ?
                      head_instr[24:20] : 5'd0;
        // Every raw immediate is already sign-extended to 32 bits, so one cast covers XLEN=64.
        dec_imm     = (dec_illegal || dec_type == TyR) ? '0 : XLEN'($signed(imm_sel));
    end

    // Output register: loads on pop, holds while stalled, drops valid on flush or handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= '0;
            bus.out_name    <= NmUnk;
            bus.out_type    <= TyUnk;
            bus.out_rd      <= '0;
            bus.out_rd_we   <= 1'b0;
            bus.out_rs1     <= '0;
            bus.out_rs2     <= '0;
            bus.out_imm     <= '0;
            bus.out_illegal <= 1'b0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (pop) begin
            bus.out_valid   <= 1'b1;
            bus.out_pc      <= head_pc;
            bus.out_name    <= dec_name;
            bus.out_type    <= dec_type;
            bus.out_rd      <= dec_rd;
            bus.out_rd_we   <= dec_rd_we;
            bus.out_rs1     <= dec_rs1;
            bus.out_rs2     <= dec_rs2;
            bus.out_imm     <= dec_imm;
            bus.out_illegal <= dec_illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Count illegal instructions actually handed to execute, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (!flush && bus.out_valid && bus.out_ready && bus.out_illegal &&
                     (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: one XLEN=32 instance for the main checks and
// an XLEN=64 / CNT_W=2 instance for wide immediates and counter saturation.
module tb_rv_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        flush64;
    logic [15:0] illegal_cnt;
    logic [1:0]  illegal_cnt64;
    int          checks = 0;
    int          passed = 0;

    rv_decode_stage_if #(.XLEN(32)) bus ();
    rv_decode_stage_if #(.XLEN(64)) bus64 ();

    rv_decode_stage #(.XLEN(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus),
        .illegal_cnt (illegal_cnt)
    );

    rv_decode_stage #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush64),
        .bus         (bus64),
        .illegal_cnt (illegal_cnt64)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [5:0]  name;
        logic [2:0]  ty;
        logic        we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } vec_t;

    // Called at a falling edge; returns at the falling edge where out_valid is seen.
    task automatic send_one(input logic [31:0] instr, input logic [31:0] pc,
                            output bit ok, output int lat);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (bus.out_valid) ok = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic send64(input logic [31:0] instr, input logic [63:0] pc, output bit ok);
        bus64.in_valid = 1'b1;
        bus64.in_instr = instr;
        bus64.in_pc    = pc;
        @(negedge clk);
        bus64.in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (bus64.out_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; flush64 = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b0)
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
        checks++; if (bus.out_name !== 6'd13)
            $display("FAIL reset_name got %0d want 13", bus.out_name); else passed++;
        checks++; if (bus.out_type !== 3'd5)
            $display("FAIL reset_type got %0d want 5", bus.out_type); else passed++;
        checks++; if (bus.out_imm !== 32'h0 || bus.out_pc !== 32'h0 || bus.out_rd_we !== 1'b0)
            $display("FAIL reset_data imm %h pc %h we %b want 0", bus.out_imm, bus.out_pc,
                     bus.out_rd_we); else passed++;
        checks++; if (illegal_cnt !== 16'd0)
            $display("FAIL reset_cnt got %0d want 0", illegal_cnt); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_addi();
        bit ok;
        int lat;
        bus.out_ready = 1'b1;
        send_one(32'hFFF00293, 32'h100, ok, lat);
        checks++; if (!ok || lat != 2)
            $display("FAIL addi_latency got ok=%b lat=%0d want ok=1 lat=2", ok, lat); else passed++;
        checks++; if (bus.out_name !== 6'd4 || bus.out_type !== 3'd1)
            $display("FAIL addi_name_type got %0d/%0d want 4/1", bus.out_name, bus.out_type);
        else passed++;
        checks++; if (bus.out_rd !== 5'd5 || bus.out_rd_we !== 1'b1)
            $display("FAIL addi_rd got %0d we %b want 5 we 1", bus.out_rd, bus.out_rd_we);
        else passed++;
        checks++; if (bus.out_imm !== 32'hFFFFFFFF)
            $display("FAIL addi_imm got %h want ffffffff", bus.out_imm); else passed++;
        checks++; if (bus.out_pc !== 32'h100)
            $display("FAIL addi_pc got %h want 00000100", bus.out_pc); else passed++;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0)
            $display("FAIL addi_handoff out_valid got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_decode_table();
        vec_t v [8];
        bit   ok;
        int   lat;
        v[0] = '{32'hFE20CEE3, 6'd28, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC}; // BLT
        v[1] = '{32'h00322423, 6'd12, 3'd4, 1'b0, 5'd0, 5'd4, 5'd3, 32'h00000008}; // SW
        v[2] = '{32'h008000EF, 6'd11, 3'd3, 1'b1, 5'd1, 5'd0, 5'd0, 32'h00000008}; // JAL
        v[3] = '{32'h4030D093, 6'd23, 3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 32'h00000003}; // SRAI
        v[4] = '{32'h00001097, 6'd27, 3'd6, 1'b1, 5'd1, 5'd0, 5'd0, 32'h00001000}; // AUIPC
        v[5] = '{32'h402081B3, 6'd1,  3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h00000000}; // SUB
        v[6] = '{32'h0000000B, 6'd13, 3'd5, 1'b0, 5'd0, 5'd0, 5'd0, 32'h00000000}; // bad opcode
        v[7] = '{32'h4000F033, 6'd13, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'h00000000}; // bad funct7
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_one(v[i].instr, 32'h300 + 32'(4 * i), ok, lat);
            checks++; if (!ok || bus.out_pc !== 32'h300 + 32'(4 * i))
                $display("FAIL dec%0d_valid_pc got ok=%b pc=%h want pc=%h", i, ok, bus.out_pc,
                         32'h300 + 32'(4 * i)); else passed++;
            checks++; if (bus.out_name !== v[i].name || bus.out_type !== v[i].ty ||
                          bus.out_illegal !== (v[i].name == 6'd13))
                $display("FAIL dec%0d_name_type got %0d/%0d ill %b want %0d/%0d", i,
                         bus.out_name, bus.out_type, bus.out_illegal, v[i].name, v[i].ty);
            else passed++;
            checks++; if (bus.out_rd !== v[i].rd || bus.out_rd_we !== v[i].we ||
                          bus.out_rs1 !== v[i].rs1 || bus.out_rs2 !== v[i].rs2)
                $display("FAIL dec%0d_regs got rd %0d we %b rs1 %0d rs2 %0d want %0d %b %0d %0d",
                         i, bus.out_rd, bus.out_rd_we, bus.out_rs1, bus.out_rs2, v[i].rd,
                         v[i].we, v[i].rs1, v[i].rs2); else passed++;
            checks++; if (bus.out_imm !== v[i].imm)
                $display("FAIL dec%0d_imm got %h want %h", i, bus.out_imm, v[i].imm);
            else passed++;
        end
        @(negedge clk);
        checks++; if (illegal_cnt !== 16'd2)
            $display("FAIL illegal_cnt got %0d want 2", illegal_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.in_ready && sent < 6) begin
                bus.in_valid = 1'b1;
                bus.in_instr = (32'(sent) << 20) | (32'(sent + 1) << 7) | 32'h13;
                bus.in_pc    = 32'h200 + 32'(4 * sent);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (sent != 5 || bus.in_ready !== 1'b0)
            $display("FAIL burst_accept got %0d in_ready %b want 5 in_ready 0", sent,
                     bus.in_ready); else passed++;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200)
            $display("FAIL burst_hold got valid %b pc %h want 1 00000200", bus.out_valid,
                     bus.out_pc); else passed++;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid) begin
                checks++; if (bus.out_pc !== 32'h200 + 32'(4 * got) ||
                              bus.out_rd !== 5'(got + 1) || bus.out_imm !== 32'(got))
                    $display("FAIL burst_item%0d got pc %h rd %0d imm %h want pc %h rd %0d",
                             got, bus.out_pc, bus.out_rd, bus.out_imm,
                             32'h200 + 32'(4 * got), got + 1); else passed++;
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 5)
            $display("FAIL burst_drain got %0d items want 5", got); else passed++;
    endtask

    task automatic test_flush();
        bit ok;
        int lat;
        int seen = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h00100093;
            bus.in_pc    = 32'h400 + 32'(4 * i);
            @(negedge clk);
        end
        flush        = 1'b1;
        bus.in_instr = 32'h00200113;
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL flush_state got valid %b in_ready %b want 0 1", bus.out_valid,
                     bus.in_ready); else passed++;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0)
            $display("FAIL flush_drop got %0d items want 0", seen); else passed++;
        checks++; if (illegal_cnt !== 16'd2)
            $display("FAIL flush_cnt got %0d want 2", illegal_cnt); else passed++;
        send_one(32'h00700493, 32'h500, ok, lat);
        checks++; if (!ok || bus.out_rd !== 5'd9 || bus.out_imm !== 32'd7 ||
                      bus.out_pc !== 32'h500)
            $display("FAIL flush_next got ok %b rd %0d imm %h pc %h want 9 7 500", ok,
                     bus.out_rd, bus.out_imm, bus.out_pc); else passed++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit ok;
        int lat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h0000000B;
            bus.in_pc    = 32'h600 + 32'(4 * i);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
                      bus.out_name !== 6'd13 || bus.out_pc !== 32'h0)
            $display("FAIL areset_out got valid %b in_ready %b name %0d pc %h want 0 1 13 0",
                     bus.out_valid, bus.in_ready, bus.out_name, bus.out_pc); else passed++;
        checks++; if (illegal_cnt !== 16'd0)
            $display("FAIL areset_cnt got %0d want 0", illegal_cnt); else passed++;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        send_one(32'hFFF00293, 32'h700, ok, lat);
        checks++; if (!ok || lat != 2 || bus.out_rd !== 5'd5 || bus.out_pc !== 32'h700)
            $display("FAIL areset_first got ok %b lat %0d rd %0d pc %h want 1 2 5 700", ok, lat,
                     bus.out_rd, bus.out_pc); else passed++;
        @(negedge clk);
    endtask

    task automatic test_xlen64();
        bit ok;
        bus64.out_ready = 1'b1;
        send64(32'h800003B7, 64'h1_0000_0040, ok);
        checks++; if (!ok || bus64.out_name !== 6'd26 || bus64.out_type !== 3'd6)
            $display("FAIL x64_lui_name got ok %b %0d/%0d want 26/6", ok, bus64.out_name,
                     bus64.out_type); else passed++;
        checks++; if (bus64.out_imm !== 64'hFFFFFFFF80000000)
            $display("FAIL x64_lui_imm got %h want ffffffff80000000", bus64.out_imm);
        else passed++;
        checks++; if (bus64.out_rd !== 5'd7 || bus64.out_rd_we !== 1'b1 ||
                      bus64.out_pc !== 64'h1_0000_0040)
            $display("FAIL x64_lui_rd got rd %0d we %b pc %h want 7 1 100000040",
                     bus64.out_rd, bus64.out_rd_we, bus64.out_pc); else passed++;
        for (int i = 0; i < 5; i++) send64(32'h0000000B, 64'h80 + 64'(4 * i), ok);
        @(negedge clk);
        checks++; if (illegal_cnt64 !== 2'd3)
            $display("FAIL x64_cnt_sat got %0d want 3", illegal_cnt64); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_decode_table();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_xlen64();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
